// File: rtl/cpu_wb_bridge.sv
// CPU-to-Wishbone bridge: one CPU request becomes one or two word-aligned
// 16-bit Wishbone classic cycles; misaligned words are split and reassembled.
module cpu_wb_bridge (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [19:0] cpu_adr_i,
  input  logic [15:0] cpu_dat_i,
  output logic [15:0] cpu_dat_o,
  input  logic        cpu_we_i,
  input  logic        cpu_mio_i,
  input  logic        cpu_byte_i,
  input  logic        cpu_stb_i,
  output logic        cpu_ack_o,
  output logic [18:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic [1:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_tga_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {IDLE, CYC1, CYC2, DONE} state_t;

  state_t      state, state_next;

  logic [19:0] req_adr;
  logic [7:0]  req_dat_hi;
  logic        req_we, req_mio, req_byte;
  logic [7:0]  lo_byte, lo_byte_next;
  logic        latch_en;

  logic [15:0] cpu_dat_next;
  logic        cpu_ack_next;
  logic [18:0] wb_adr_next;
  logic [15:0] wb_dat_next;
  logic [1:0]  wb_sel_next;
  logic        wb_we_next, wb_tga_next, wb_cyc_next, wb_stb_next;

  logic        split;
  logic        ack_seen;
  logic [19:0] adr_second;

  // Memory space wraps across all 20 bits; I/O space wraps within 64K.
  function automatic logic [19:0] next_adr(input logic [19:0] a, input logic mio);
    if (mio) return a + 20'd1;
    return {a[19:16], a[15:0] + 16'd1};
  endfunction

  assign split      = !req_byte && req_adr[0];
  assign ack_seen   = wb_ack_i && wb_stb_o;
  assign adr_second = next_adr(req_adr, req_mio);

  always_comb begin
    state_next   = state;
    latch_en     = 1'b0;
    lo_byte_next = lo_byte;
    cpu_dat_next = cpu_dat_o;
    cpu_ack_next = 1'b0;
    wb_adr_next  = wb_adr_o;
    wb_dat_next  = wb_dat_o;
    wb_sel_next  = wb_sel_o;
    wb_we_next   = wb_we_o;
    wb_tga_next  = wb_tga_o;
    wb_cyc_next  = wb_cyc_o;
    wb_stb_next  = wb_stb_o;
    case (state)
      IDLE: begin
        if (cpu_stb_i) begin
          latch_en    = 1'b1;
          state_next  = CYC1;
          wb_adr_next = cpu_adr_i[19:1];
          wb_we_next  = cpu_we_i;
          wb_tga_next = cpu_mio_i;
          wb_cyc_next = 1'b1;
          wb_stb_next = 1'b1;
          if (cpu_byte_i || cpu_adr_i[0]) begin
            wb_dat_next = {cpu_dat_i[7:0], cpu_dat_i[7:0]};
            wb_sel_next = (cpu_adr_i[0]) ? 2'b10 : 2'b01;
          end else begin
            wb_dat_next = cpu_dat_i;
            wb_sel_next = 2'b11;
          end
        end
      end
      CYC1: begin
        if (ack_seen) begin
          if (split) begin
            state_next   = CYC2;
            lo_byte_next = wb_dat_i[15:8];
            wb_adr_next  = adr_second[19:1];
            wb_sel_next  = 2'b01;
            wb_dat_next  = {req_dat_hi, req_dat_hi};
          end else begin
            state_next   = DONE;
            cpu_ack_next = 1'b1;
            wb_cyc_next  = 1'b0;
            wb_stb_next  = 1'b0;
            if (!req_we) begin
              if (req_byte)
                cpu_dat_next = {8'h00, (req_adr[0] ? wb_dat_i[15:8] : wb_dat_i[7:0])};
              else
                cpu_dat_next = wb_dat_i;
            end
          end
        end
      end
      CYC2: begin
        if (ack_seen) begin
          state_next   = DONE;
          cpu_ack_next = 1'b1;
          wb_cyc_next  = 1'b0;
          wb_stb_next  = 1'b0;
          if (!req_we) cpu_dat_next = {wb_dat_i[7:0], lo_byte};
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control state and all outputs: cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cpu_dat_o <= '0;
      cpu_ack_o <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_tga_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
    end else begin
      state     <= state_next;
      cpu_dat_o <= cpu_dat_next;
      cpu_ack_o <= cpu_ack_next;
      wb_adr_o  <= wb_adr_next;
      wb_dat_o  <= wb_dat_next;
      wb_sel_o  <= wb_sel_next;
      wb_we_o   <= wb_we_next;
      wb_tga_o  <= wb_tga_next;
      wb_cyc_o  <= wb_cyc_next;
      wb_stb_o  <= wb_stb_next;
    end
  end

  // Request fields and the partial result: only meaningful inside a transfer
  always_ff @(posedge clk_i) begin
    lo_byte <= lo_byte_next;
    if (latch_en) begin
      req_adr    <= cpu_adr_i;
      req_dat_hi <= cpu_dat_i[15:8];
      req_we     <= cpu_we_i;
      req_mio    <= cpu_mio_i;
      req_byte   <= cpu_byte_i;
    end
  end

endmodule

// File: tb/tb_cpu_wb_bridge.sv
// Directed self-checking bench for cpu_wb_bridge with a hand-driven Wishbone slave.
module tb_cpu_wb_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [19:0] cpu_adr_i;
  logic [15:0] cpu_dat_i;
  logic [15:0] cpu_dat_o;
  logic        cpu_we_i, cpu_mio_i, cpu_byte_i, cpu_stb_i, cpu_ack_o;
  logic [18:0] wb_adr_o;
  logic [15:0] wb_dat_o, wb_dat_i;
  logic [1:0]  wb_sel_o;
  logic        wb_we_o, wb_tga_o, wb_cyc_o, wb_stb_o, wb_ack_i;

  int compared   = 0;
  int mismatched = 0;

  cpu_wb_bridge dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i), .cpu_dat_o(cpu_dat_o),
    .cpu_we_i(cpu_we_i), .cpu_mio_i(cpu_mio_i), .cpu_byte_i(cpu_byte_i),
    .cpu_stb_i(cpu_stb_i), .cpu_ack_o(cpu_ack_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_tga_o(wb_tga_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [19:0] adr, input logic [15:0] dat,
                     input logic we, input logic mio, input logic byt);
    cpu_adr_i  = adr;
    cpu_dat_i  = dat;
    cpu_we_i   = we;
    cpu_mio_i  = mio;
    cpu_byte_i = byt;
    cpu_stb_i  = 1'b1;
  endtask

  // One Wishbone beat: wait for the strobe, check the request, ack after 'waits' cycles.
  task automatic wb_beat(input string tag, input logic [18:0] eadr, input logic [1:0] esel,
                         input logic ewe, input logic etga, input logic chkdat,
                         input logic [15:0] edat, input logic [15:0] rdat, input int waits);
    int n = 0;
    while (!(wb_cyc_o && wb_stb_o) && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, ".stb"}, 32'(wb_stb_o), 32'd1);
    chk({tag, ".adr"}, 32'(wb_adr_o), 32'(eadr));
    chk({tag, ".sel"}, 32'(wb_sel_o), 32'(esel));
    chk({tag, ".we"},  32'(wb_we_o),  32'(ewe));
    chk({tag, ".tga"}, 32'(wb_tga_o), 32'(etga));
    if (chkdat) chk({tag, ".dat"}, 32'(wb_dat_o), 32'(edat));
    for (int i = 0; i < waits; i++) begin
      @(negedge clk_i);
      chk({tag, ".wait_stb"}, 32'(wb_stb_o), 32'd1);
    end
    wb_dat_i = rdat;
    wb_ack_i = 1'b1;
    @(negedge clk_i);
    wb_ack_i = 1'b0;
    wb_dat_i = 16'h0000;
  endtask

  // Called in the DONE cycle: check the pulse and data, drop the request, check pulse ends.
  task automatic finish_req(input string tag, input logic [15:0] edat);
    chk({tag, ".ack"},  32'(cpu_ack_o), 32'd1);
    chk({tag, ".rdat"}, 32'(cpu_dat_o), 32'(edat));
    chk({tag, ".cyc_done"}, 32'(wb_cyc_o), 32'd0);
    cpu_stb_i = 1'b0;
    @(negedge clk_i);
    chk({tag, ".ack_once"}, 32'(cpu_ack_o), 32'd0);
    @(negedge clk_i);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0;
    cpu_adr_i = '0; cpu_dat_i = '0; cpu_we_i = 1'b0; cpu_mio_i = 1'b0;
    cpu_byte_i = 1'b0; cpu_stb_i = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0;
    #12;
    chk("rst.cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst.stb", 32'(wb_stb_o), 32'd0);
    chk("rst.ack", 32'(cpu_ack_o), 32'd0);
    chk("rst.dat", 32'(cpu_dat_o), 32'd0);
    chk("rst.adr", 32'(wb_adr_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Aligned memory word read with two wait states
    req(20'h01234, 16'h0000, 1'b0, 1'b1, 1'b0);
    wb_beat("ard", 19'h0091A, 2'b11, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hBEEF, 2);
    finish_req("ard", 16'hBEEF);

    // Byte read from an even address picks the low lane
    req(20'h00010, 16'h0000, 1'b0, 1'b1, 1'b1);
    wb_beat("brd", 19'h00008, 2'b01, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h12AB, 0);
    finish_req("brd", 16'h00AB);

    // Byte write to odd address; read data stays at the last read value
    req(20'h00007, 16'h0055, 1'b1, 1'b1, 1'b1);
    wb_beat("bwr", 19'h00003, 2'b10, 1'b1, 1'b1, 1'b1, 16'h5555, 16'h0000, 0);
    finish_req("bwr", 16'h00AB);

    // Misaligned word write, split into two beats
    req(20'h00101, 16'hA1B2, 1'b1, 1'b1, 1'b0);
    wb_beat("mwr1", 19'h00080, 2'b10, 1'b1, 1'b1, 1'b1, 16'hB2B2, 16'h0000, 1);
    chk("mwr.cyc_cont", 32'(wb_cyc_o), 32'd1);
    chk("mwr.stb_cont", 32'(wb_stb_o), 32'd1);
    wb_beat("mwr2", 19'h00081, 2'b01, 1'b1, 1'b1, 1'b1, 16'hA1A1, 16'h0000, 0);
    finish_req("mwr", 16'h00AB);

    // Memory wrap read at the top of the address space
    req(20'hFFFFF, 16'h0000, 1'b0, 1'b1, 1'b0);
    wb_beat("mwrap1", 19'h7FFFF, 2'b10, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h3400, 0);
    wb_beat("mwrap2", 19'h00000, 2'b01, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0012, 0);
    finish_req("mwrap", 16'h1234);

    // I/O wrap read: only the low 16 address bits wrap
    req(20'h3FFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
    wb_beat("iowrap1", 19'h1FFFF, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hAB00, 0);
    wb_beat("iowrap2", 19'h18000, 2'b01, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00CD, 0);
    finish_req("iowrap", 16'hCDAB);

    // Reset during the second beat abandons the transfer
    req(20'h00101, 16'h0000, 1'b0, 1'b1, 1'b0);
    wb_beat("rmid1", 19'h00080, 2'b10, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h7700, 0);
    chk("rmid.in_cyc2", 32'(wb_adr_o), 32'h00081);
    rst_ni = 1'b0;
    #1;
    chk("rmid.cyc", 32'(wb_cyc_o), 32'd0);
    chk("rmid.stb", 32'(wb_stb_o), 32'd0);
    chk("rmid.adr", 32'(wb_adr_o), 32'd0);
    chk("rmid.sel", 32'(wb_sel_o), 32'd0);
    chk("rmid.dat_o", 32'(cpu_dat_o), 32'd0);
    @(negedge clk_i);
    chk("rmid.noack", 32'(cpu_ack_o), 32'd0);
    rst_ni = 1'b1;
    wb_beat("rre1", 19'h00080, 2'b10, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h7700, 0);
    wb_beat("rre2", 19'h00081, 2'b01, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0066, 1);
    finish_req("rre", 16'h6677);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cpu_wb_bridge.md
# cpu_wb_bridge

Bus bridge directly downstream of the CPU core's memory port. It accepts one CPU request at a time (20-bit byte address, byte/word size, memory/I-O select, read/write) and turns it into one or two 16-bit, word-aligned Wishbone classic cycles with byte selects. Misaligned word accesses are split into two cycles. The CPU sees a single acknowledge with the data already assembled.

## Interface
Parameters: none.

Ports:
- clk_i  in  1  system clock; all logic on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- cpu_adr_i  in  20  byte address of request
- cpu_dat_i  in  16  write data from CPU
- cpu_dat_o  out  16  read data to CPU, registered
- cpu_we_i  in  1  1 = write, 0 = read
- cpu_mio_i  in  1  1 = memory, 0 = I/O
- cpu_byte_i  in  1  1 = byte access, 0 = word access
- cpu_stb_i  in  1  request valid; CPU holds it and all request fields stable until cpu_ack_o
- cpu_ack_o  out  1  one-cycle completion pulse
- wb_adr_o  out  19  word address (byte address bits 19:1)
- wb_dat_o  out  16  write data
- wb_dat_i  in  16  read data
- wb_sel_o  out  2  byte lane enables; bit 0 = low byte (even address)
- wb_we_o  out  1  write enable
- wb_tga_o  out  1  address tag, copy of cpu_mio_i
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  slave acknowledge

## Operation
- FSM states: IDLE, CYC1, CYC2, DONE.
- IDLE: when cpu_stb_i=1, latch adr, dat, we, mio, byte and go to CYC1. Drive the first-cycle wb_* outputs in the same registered update.
- Cycle classification:
  - byte: one cycle; sel = adr[0] ? 10 : 01; wb_dat_o = {d[7:0], d[7:0]}.
  - word, adr[0]=0: one cycle; sel = 11; wb_dat_o = d.
  - word, adr[0]=1: two cycles.
    - Cycle 1 at adr[19:1], sel = 10, wb_dat_o = {d[7:0], d[7:0]}.
    - Cycle 2 at adr+1, sel = 01, wb_dat_o = {d[15:8], d[15:8]}.
- Second-cycle address arithmetic:
  - memory: 20-bit increment, wrapping 0xFFFFF -> 0x00000.
  - I/O: increment adr[15:0] only (wraps 0xFFFF -> 0x0000); adr[19:16] held.
- CYC1 on wb_ack_i:
  - single-cycle access: go to DONE.
  - split access: capture wb_dat_i[15:8] as the result low byte, load the cycle-2 adr/sel/dat, go to CYC2.
- CYC2 on wb_ack_i: capture wb_dat_i[7:0] as the result high byte; go to DONE.
- Read data returned to the CPU:
  - byte read: {8'h00, selected lane}.
  - aligned word read: wb_dat_i.
  - split word read: {cycle-2 low lane, cycle-1 high lane}.
- DONE: cpu_ack_o=1 for exactly this cycle, cpu_dat_o valid; wb_cyc_o=wb_stb_o=0. cpu_stb_i is ignored here. Next state is always IDLE, so a held strobe never retriggers the completed request.
- Writes return cpu_dat_o unchanged (the last read value).

## Timing
- Reset values (asserted asynchronously while rst_ni=0): all outputs 0. That includes cpu_ack_o, cpu_dat_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_tga_o, wb_cyc_o and wb_stb_o. FSM = IDLE.
- Reset mid-transfer abandons the transaction: no cpu_ack_o, no partial result kept. After release, the bridge restarts from IDLE.
- wb_cyc_o and wb_stb_o:
  - Asserted the cycle after cpu_stb_i is sampled in IDLE.
  - Both stay high for the whole access, including continuously across the CYC1->CYC2 boundary.
  - The cycle-2 address is presented the cycle after the first wb_ack_i.
- wb_ack_i is sampled only while wb_stb_o=1. The bridge waits indefinitely; there is no timeout.
- Latency from cpu_stb_i sampled to cpu_ack_o, with a zero-wait slave (ack in the first strobe cycle): 3 cycles for a single access, 4 for a split access. Each slave wait state adds 1.
- Minimum request spacing: a new request can be sampled 1 cycle after cpu_ack_o.

## Test plan
- Aligned word read: mem, adr 0x01234; slave acks with 0xBEEF after 2 wait states -> one cycle with wb_adr_o=0x0091A, sel=11, wb_tga_o=1; cpu_dat_o=0xBEEF; exactly one cpu_ack_o pulse.
- Byte write: 0x55 to 0x00007 -> one cycle with wb_adr_o=0x00003, sel=10, wb_we_o=1, wb_dat_o=0x5555.
- Misaligned word write: 0xA1B2 to 0x00101 -> cycle 1 has adr 0x00080, sel=10, dat[15:8]=0xB2; cycle 2 has adr 0x00081, sel=01, dat[7:0]=0xA1; wb_cyc_o stays high throughout; one cpu_ack_o.
- Memory wrap read: word at 0xFFFFF; slave returns 0x3400 then 0x0012 -> cycle 1 adr 0x7FFFF sel=10; cycle 2 adr 0x00000 sel=01; cpu_dat_o=0x1234.
- I/O wrap read: word at 0x3FFFF with mio=0 -> cycle-2 byte address is 0x30000 (wb_adr_o=0x18000); wb_tga_o=0 in both cycles.
- Reset mid-transfer: pull rst_ni low during CYC2 -> all outputs 0 immediately, no cpu_ack_o. Release with cpu_stb_i held -> the access restarts from cycle 1 and completes normally.
